cache_req_arbiter: RTL and testbench



---
 rtl/cache_req_arbiter.sv | 124 ++++++++++++
 tb/tb_cache_req_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/cache_req_arbiter.sv
// Two-requester round-robin arbiter/sequencer for the cache model: accept -> start -> wait done/watchdog -> 1-cycle tagged response.
// Latency >= 3 cycles accept-to-response, grants >= 4 cycles apart; ready only in IDLE. `ARB_STATS_EN adds grant/abort counters.
module cache_req_arbiter #(
  parameter int ADDR_W  = 48,
  parameter int OP_W    = 8,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req0_lvl,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [OP_W-1:0]   req1_op,
  input  logic              req1_lvl,
  output logic              req1_ready,
  output logic [ADDR_W-1:0] cache_addr,
  output logic [OP_W-1:0]   cache_op,
  output logic              cache_lvl,
  output logic              cache_start,
  input  logic              cache_done,
  output logic              resp_valid,
  output logic              resp_id,
  output logic              resp_err,
  output logic              busy,
  output logic              timeout_err
`ifdef ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]  grant_cnt0,
  output logic [CNT_W-1:0]  grant_cnt1,
  output logic [CNT_W-1:0]  abort_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam int TW = 16;
  localparam logic [TW-1:0] WDOG_LAST = TW'(TIMEOUT - 1);

  state_t          state, state_nxt;
  logic            rr;
  logic [TW-1:0]   wdog;
  logic            xfer;
  logic            expire;

  // rr = 1 gives requester 1 priority when both are valid
  assign req0_ready = (state == S_IDLE) && req0_valid && (!req1_valid || !rr);
  assign req1_ready = (state == S_IDLE) && req1_valid && (!req0_valid || rr);
  assign xfer       = req0_ready || req1_ready;
  assign expire     = (state == S_WAIT) && !cache_done && (wdog == WDOG_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (xfer) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (cache_done || (wdog == WDOG_LAST)) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cache_addr  <= '0;
      cache_op    <= '0;
      cache_lvl   <= 1'b0;
      cache_start <= 1'b0;
      resp_valid  <= 1'b0;
      resp_id     <= 1'b0;
      resp_err    <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      rr          <= 1'b0;
      wdog        <= '0;
    end else begin
      cache_start <= (state_nxt == S_ISSUE);
      resp_valid  <= (state_nxt == S_RESP);
      busy        <= (state_nxt != S_IDLE);
      // Cache bus only moves on a grant, so the cache sees exactly one address change per access
      if (xfer) begin
        cache_addr <= req1_ready ? req1_addr : req0_addr;
        cache_op   <= req1_ready ? req1_op   : req0_op;
        cache_lvl  <= req1_ready ? req1_lvl  : req0_lvl;
        resp_id    <= req1_ready;
        resp_err   <= 1'b0;
      end
      if (state == S_ISSUE)
        wdog <= '0;
      else if ((state == S_WAIT) && (wdog != WDOG_LAST))
        wdog <= wdog + 1'b1;
      if (expire) begin
        resp_err    <= 1'b1;
        timeout_err <= 1'b1;
      end
      if (state == S_RESP)
        rr <= ~resp_id;
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
      abort_cnt  <= '0;
    end else begin
      if (req0_ready) grant_cnt0 <= grant_cnt0 + 1'b1;
      if (req1_ready) grant_cnt1 <= grant_cnt1 + 1'b1;
      if (expire)     abort_cnt  <= abort_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Directed bench for cache_req_arbiter (TIMEOUT = 8); stats checks compile in with ARB_STATS_EN.
module tb_cache_req_arbiter;
  localparam int AW = 48;
  localparam int OW = 8;
  localparam int TO = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic [AW-1:0] req0_addr = '0, req1_addr = '0;
  logic [OW-1:0] req0_op = '0, req1_op = '0;
  logic          req0_lvl = 1'b0, req1_lvl = 1'b0;
  logic          req0_ready, req1_ready;
  logic [AW-1:0] cache_addr;
  logic [OW-1:0] cache_op;
  logic          cache_lvl, cache_start;
  logic          cache_done = 1'b0;
  logic          resp_valid, resp_id, resp_err, busy, timeout_err;
`ifdef ARB_STATS_EN
  logic [CW-1:0] grant_cnt0, grant_cnt1, abort_cnt;
`endif

  int checks = 0;
  int errors = 0;

  cache_req_arbiter #(.ADDR_W(AW), .OP_W(OW), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_op(req0_op), .req0_lvl(req0_lvl),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_op(req1_op), .req1_lvl(req1_lvl),
    .req1_ready(req1_ready),
    .cache_addr(cache_addr), .cache_op(cache_op), .cache_lvl(cache_lvl),
    .cache_start(cache_start), .cache_done(cache_done),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_err(resp_err),
    .busy(busy), .timeout_err(timeout_err)
`ifdef ARB_STATS_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .abort_cnt(abort_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // advance n rising edges, then settle 1 time unit past the edge
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  initial begin
    int n0, n1, seen;
    step(2);
    chk("rst_busy",  64'(busy), 64'd0);
    chk("rst_start", 64'(cache_start), 64'd0);
    chk("rst_resp",  64'(resp_valid), 64'd0);
    chk("rst_addr",  64'(cache_addr), 64'd0);
    chk("rst_toerr", 64'(timeout_err), 64'd0);
    chk("rst_rdy0",  64'(req0_ready), 64'd0);
    reset = 1'b0;

    // single request, done sampled at edge T+4
    req0_valid = 1'b1; req0_addr = 48'h1000; req0_op = 8'h52; req0_lvl = 1'b1;
    #1;
    chk("t1_rdy0", 64'(req0_ready), 64'd1);
    chk("t1_rdy1", 64'(req1_ready), 64'd0);
    step(1);
    req0_valid = 1'b0;
    chk("t1_start", 64'(cache_start), 64'd1);
    chk("t1_busy",  64'(busy), 64'd1);
    chk("t1_addr",  64'(cache_addr), 64'h1000);
    chk("t1_op",    64'(cache_op), 64'h52);
    chk("t1_lvl",   64'(cache_lvl), 64'd1);
    step(1);
    chk("t1_start_off", 64'(cache_start), 64'd0);
    step(2);
    chk("t1_no_early", 64'(resp_valid), 64'd0);
    cache_done = 1'b1;
    step(1);
    cache_done = 1'b0;
    chk("t1_resp",  64'(resp_valid), 64'd1);
    chk("t1_id",    64'(resp_id), 64'd0);
    chk("t1_err",   64'(resp_err), 64'd0);
    step(1);
    chk("t1_resp_off", 64'(resp_valid), 64'd0);
    chk("t1_idle",     64'(busy), 64'd0);
    chk("t1_hold",     64'(cache_addr), 64'h1000);

    // contention: done held high, both valid -> 0,1,0,1
    do_reset();
    cache_done = 1'b1;
    req0_valid = 1'b1; req0_addr = 48'hA0;
    req1_valid = 1'b1; req1_addr = 48'hB0;
    n0 = 0; n1 = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_rdy0", 64'(req0_ready), 64'((i % 2) == 0));
      chk("t2_rdy1", 64'(req1_ready), 64'((i % 2) == 1));
      if (req0_ready) n0++;
      if (req1_ready) n1++;
      step(3);
      chk("t2_resp", 64'(resp_valid), 64'd1);
      chk("t2_id",   64'(resp_id), 64'(i % 2));
      step(1);
    end
    chk("t2_n0", 64'(n0), 64'd2);
    chk("t2_n1", 64'(n1), 64'd2);
    req0_valid = 1'b0; req1_valid = 1'b0; cache_done = 1'b0;

    // timeout: no done, response after edge T+9
    req0_valid = 1'b1; req0_addr = 48'h2000; req0_op = 8'h57;
    #1;
    chk("t3_rdy0", 64'(req0_ready), 64'd1);
    step(1);
    req0_valid = 1'b0;
    step(8);
    chk("t3_no_early", 64'(resp_valid), 64'd0);
    step(1);
    chk("t3_resp",  64'(resp_valid), 64'd1);
    chk("t3_err",   64'(resp_err), 64'd1);
    chk("t3_toerr", 64'(timeout_err), 64'd1);
    chk("t3_id",    64'(resp_id), 64'd0);
    step(1);
    chk("t3_resp_off", 64'(resp_valid), 64'd0);
    chk("t3_sticky",   64'(timeout_err), 64'd1);
    // following request completes normally
    cache_done = 1'b1;
    req1_valid = 1'b1; req1_addr = 48'h3000; req1_op = 8'h57; req1_lvl = 1'b0;
    #1;
    chk("t3b_rdy1", 64'(req1_ready), 64'd1);
    step(1);
    req1_valid = 1'b0;
    step(2);
    chk("t3b_resp",  64'(resp_valid), 64'd1);
    chk("t3b_id",    64'(resp_id), 64'd1);
    chk("t3b_err",   64'(resp_err), 64'd0);
    chk("t3b_toerr", 64'(timeout_err), 64'd1);
    chk("t3b_addr",  64'(cache_addr), 64'h3000);
    chk("t3b_lvl",   64'(cache_lvl), 64'd0);
    step(1);
    cache_done = 1'b0;
`ifdef ARB_STATS_EN
    chk("st_g0",    64'(grant_cnt0), 64'd3);
    chk("st_g1",    64'(grant_cnt1), 64'd3);
    chk("st_abort", 64'(abort_cnt), 64'd1);
`endif

    // done in the same WAIT cycle as expiry: done wins
    do_reset();
    chk("t4_toerr_rst", 64'(timeout_err), 64'd0);
    req0_valid = 1'b1; req0_addr = 48'h4000;
    step(1);
    req0_valid = 1'b0;
    step(8);
    chk("t4_no_early", 64'(resp_valid), 64'd0);
    cache_done = 1'b1;
    step(1);
    cache_done = 1'b0;
    chk("t4_resp",  64'(resp_valid), 64'd1);
    chk("t4_err",   64'(resp_err), 64'd0);
    chk("t4_toerr", 64'(timeout_err), 64'd0);
    step(1);

    // async reset while in WAIT (rr is 1 beforehand)
    req0_valid = 1'b1; req0_addr = 48'h5000;
    step(1);
    req0_valid = 1'b0;
    step(2);
    #3;
    reset = 1'b1;
    #1;
    chk("t5_busy",  64'(busy), 64'd0);
    chk("t5_start", 64'(cache_start), 64'd0);
    chk("t5_resp",  64'(resp_valid), 64'd0);
    chk("t5_addr",  64'(cache_addr), 64'd0);
    step(1);
    reset = 1'b0;
    cache_done = 1'b1;
    seen = 0;
    repeat (6) begin
      step(1);
      if (resp_valid) seen++;
    end
    chk("t5_no_resp", 64'(seen), 64'd0);
    cache_done = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("t5_rr_rdy0", 64'(req0_ready), 64'd1);
    chk("t5_rr_rdy1", 64'(req1_ready), 64'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    step(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
